// File: rtl/apb_master_mc.sv
// apb_master_mc: multi-slave APB master with a valid/ready command port.
// Handles back-to-back transfers, PSTRB, decode errors and PREADY timeout.
module apb_master_mc #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLAVES = 4,
   parameter int SEL_LSB    = 6,
   parameter int TIMEOUT    = 16
) (
   input  logic                             PCLK,
   input  logic                             PRESET,
   input  logic                             Transfer,
   output logic                             cmd_ready,
   input  logic                             Wr_Rd,
   input  logic [ADDR_WIDTH-1:0]            Address,
   input  logic [DATA_WIDTH-1:0]            write_data,
   input  logic [DATA_WIDTH/8-1:0]          write_strb,
   output logic                             rsp_valid,
   output logic                             rsp_err,
   output logic [DATA_WIDTH-1:0]            read_data,
   output logic [ADDR_WIDTH-1:0]            PADDR,
   output logic [NUM_SLAVES-1:0]            PSELx,
   output logic                             PENABLE,
   output logic                             PWRITE,
   output logic [DATA_WIDTH-1:0]            PWDATA,
   output logic [DATA_WIDTH/8-1:0]          PSTRB,
   input  logic [NUM_SLAVES-1:0]            PREADY,
   input  logic [NUM_SLAVES-1:0]            PSLVERR,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA
);

   localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int SB = DATA_WIDTH / 8;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SW:0] NSL = (SW + 1)'(NUM_SLAVES);
   localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [NUM_SLAVES-1:0] ONE = NUM_SLAVES'(1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t                  state_q;
   logic [SW-1:0]           idx_q;
   logic [CW-1:0]           wcnt_q;
   logic                    pend_q;
   logic [ADDR_WIDTH-1:0]   paddr_q;
   logic [NUM_SLAVES-1:0]   psel_q;
   logic                    penable_q;
   logic                    pwrite_q;
   logic [DATA_WIDTH-1:0]   pwdata_q;
   logic [SB-1:0]           pstrb_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    rsp_valid_q;
   logic                    rsp_err_q;

   logic [SW-1:0]           in_idx;
   logic                    dec_err;
   logic [NUM_SLAVES-1:0]   psel_d;
   logic                    mux_ready;
   logic                    mux_err;
   logic [DATA_WIDTH-1:0]   mux_rdata;
   logic                    sel_ready;
   logic                    timeout_hit;
   logic                    accept;
   logic                    pend_d;

   assign in_idx  = Address[SEL_LSB +: SW];
   assign dec_err = {1'b0, in_idx} >= NSL;
   assign psel_d  = ONE << in_idx;

   // Route the selected slave's response; all other slaves are ignored.
   always_comb begin
      mux_ready = 1'b0;
      mux_err   = 1'b0;
      mux_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == SW'(i)) begin
            mux_ready = PREADY[i];
            mux_err   = PSLVERR[i];
            mux_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign sel_ready   = (state_q == ACCESS) && mux_ready;
   assign timeout_hit = (TIMEOUT != 0) && (wcnt_q == TLAST);
   assign cmd_ready   = !PRESET && ((state_q == IDLE) || sel_ready);
   assign accept      = Transfer && cmd_ready;

   // A decode error accepted while the response slot is taken is deferred
   // by one cycle so that no response is ever lost.
   assign pend_d = accept && dec_err && ((state_q == ACCESS) || pend_q);

   // Bus FSM with registered APB and response outputs.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         wcnt_q      <= '0;
         pend_q      <= 1'b0;
         paddr_q     <= '0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         pend_q      <= pend_d;
         unique case (state_q)
            IDLE: begin
               if (pend_q || (accept && dec_err)) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rdata_q     <= '0;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               wcnt_q    <= '0;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               if (sel_ready) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= mux_err;
                  if (!pwrite_q) begin
                     rdata_q <= mux_err ? '0 : mux_rdata;
                  end
                  state_q   <= IDLE;
                  psel_q    <= '0;
                  penable_q <= 1'b0;
               end else if (timeout_hit) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rdata_q     <= '0;
                  state_q     <= IDLE;
                  psel_q      <= '0;
                  penable_q   <= 1'b0;
               end else begin
                  wcnt_q <= wcnt_q + 1'b1;
               end
            end
            default: begin
               state_q   <= IDLE;
               psel_q    <= '0;
               penable_q <= 1'b0;
            end
         endcase
         if (accept) begin
            paddr_q   <= Address;
            pwrite_q  <= Wr_Rd;
            pwdata_q  <= write_data;
            pstrb_q   <= Wr_Rd ? write_strb : '0;
            penable_q <= 1'b0;
            if (dec_err) begin
               psel_q  <= '0;
               state_q <= IDLE;
            end else begin
               psel_q  <= psel_d;
               idx_q   <= in_idx;
               state_q <= SETUP;
            end
         end
      end
   end

   assign PADDR     = paddr_q;
   assign PSELx     = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PWDATA    = pwdata_q;
   assign PSTRB     = pstrb_q;
   assign read_data = rdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master_mc.md
# apb_master_mc

Parametrised multi-slave APB master for the peripheral bus. It accepts single read/write commands over a valid/ready handshake and drives the APB SETUP/ACCESS sequence. It decodes one-hot PSELx across NUM_SLAVES, muxes the per-slave response signals, and returns read data and error status on a one-cycle response strobe. It adds the following features:
- back-to-back transfers
- PSTRB byte strobes
- address-decode errors
- PREADY timeout

## Interface
Parameters:
- ADDR_WIDTH, 8: width of Address/PADDR.
- DATA_WIDTH, 32: data width; must be a multiple of 8.
- NUM_SLAVES, 4: number of PSELx lines, 1..16.
- SEL_LSB, 6: lowest Address bit of the slave-index field. The field width is SW = max(1, clog2(NUM_SLAVES)).
- TIMEOUT, 16: maximum ACCESS cycles per transfer. A value of 0 disables the timeout.

Ports:
- PCLK, in, 1: clock. Everything is sampled on the rising edge.
- PRESET, in, 1: synchronous, active-high reset.
- Transfer, in, 1: command valid.
- cmd_ready, out, 1: command accepted on an edge where Transfer && cmd_ready.
- Wr_Rd, in, 1: 1 = write, 0 = read.
- Address, in, ADDR_WIDTH: byte address.
- write_data, in, DATA_WIDTH: write payload.
- write_strb, in, DATA_WIDTH/8: byte enables for writes.
- rsp_valid, out, 1: one-cycle pulse when a command completes.
- rsp_err, out, 1: error status, valid while rsp_valid.
- read_data, out, DATA_WIDTH: read result. Holds its value until the next response.
- PADDR, out, ADDR_WIDTH: APB address.
- PSELx, out, NUM_SLAVES: one-hot slave select.
- PENABLE, PWRITE, out, 1 each: APB enable and direction.
- PWDATA, out, DATA_WIDTH: APB write data.
- PSTRB, out, DATA_WIDTH/8: APB byte strobes.
- PREADY, PSLVERR, in, NUM_SLAVES each: per-slave ready and error.
- PRDATA, in, NUM_SLAVES*DATA_WIDTH: per-slave read data. Slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
States:
- IDLE, SETUP, ACCESS.

Reset:
- Reset wins over all other activity.
- Next state is IDLE.
- Every output register is cleared to 0: PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, read_data, rsp_valid, rsp_err.
- A transfer in flight when reset asserts is dropped and produces no response.

cmd_ready (combinational):
- High when state is IDLE.
- Also high in ACCESS when sel_ready is high. sel_ready = PREADY[idx] and means the transfer completes this edge.
- Low in every other case, including while PRESET is high.

Command acceptance:
- Address, Wr_Rd, write_data and write_strb are captured into PADDR, PWRITE, PWDATA and PSTRB.
- PSTRB is forced to 0 for reads.
- idx = Address[SEL_LSB +: SW].

Decode error (idx >= NUM_SLAVES):
- No bus cycle is started; the state goes to or stays in IDLE.
- The next cycle has rsp_valid=1, rsp_err=1, read_data=0.

Valid decode:
- SETUP: PSELx = 1<<idx, PENABLE=0. Always exactly one cycle, then ACCESS.
- ACCESS: PSELx held, PENABLE=1. PADDR, PWRITE, PWDATA and PSTRB stay stable from SETUP to completion.

Completion (ACCESS edge with sel_ready=1):
- rsp_valid=1 in the next cycle.
- rsp_err = PSLVERR[idx].
- For reads, read_data = PRDATA slice idx. On error read_data = 0.
- For writes, read_data is unchanged.
- If a new command is accepted on the same edge, go to SETUP with the new PSELx. PENABLE drops to 0.
- Otherwise go to IDLE with PSELx=0 and PENABLE=0.

Wait states:
- ACCESS with sel_ready=0 holds.
- Responses from unselected slaves are ignored.

Timeout (TIMEOUT>0):
- A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with sel_ready=0.
- When it reaches TIMEOUT-1 with sel_ready still 0 (TIMEOUT ACCESS cycles without PREADY), abort:
  - Next state is IDLE, PSELx=0, PENABLE=0.
  - rsp_valid=1, rsp_err=1, read_data=0.
  - cmd_ready is not asserted on the abort edge.
- If PREADY arrives on the same edge as the timeout, it counts as a normal completion.

## Timing
Single transfer accepted at edge T:
- T+1: SETUP.
- T+2 onward: ACCESS.
- With zero wait states, complete at edge T+2. rsp_valid is high in cycle T+2..T+3.

Latency:
- Command acceptance to rsp_valid is 2 + W cycles, where W is the number of wait states.
- Back-to-back throughput is one transfer per 2+W cycles. No IDLE cycle is inserted between transfers.

Decode error:
- rsp_valid in the cycle after acceptance.
- cmd_ready stays high, so back-to-back decode errors are accepted every cycle.

Response strobe:
- rsp_valid is never high for two consecutive cycles unless those are two separate completions.

## Test plan
- Reset then write: Address=0x44, data 0xDEADBEEF, strb 0xF, slave 1 PREADY=1 → PSELx=0010 for exactly 2 cycles, then SETUP/ACCESS. PENABLE is high only in the second cycle. rsp_valid pulses once with rsp_err=0.
- Read from slave 2 with 3 wait states, PRDATA slice = 0x12345678 → ACCESS lasts 4 cycles. read_data=0x12345678 five cycles after acceptance. PSTRB=0 throughout.
- Two back-to-back writes, both slaves ready:
  - PSELx goes 0001, 0001, 0100, 0100 with no IDLE between.
  - PENABLE goes 0,1,0,1.
  - Two rsp_valid pulses, two cycles apart.
- PSLVERR=1 on read completion → rsp_err=1 and read_data=0. The next clean read returns the correct data.
- NUM_SLAVES=3, Address index 3 → no PSELx activity, rsp_valid=1 with rsp_err=1 one cycle later. TIMEOUT=4 with PREADY stuck low → abort after 4 ACCESS cycles with rsp_err=1 and PSELx=0.
- Assert PRESET during ACCESS → next cycle every output is 0, state is IDLE, and no rsp_valid is produced. After release, a new transfer completes normally.
